// File: rtl/sc_axi_master_bridge.sv
// Turns single transaction requests from the SystemC side into AXI4 INCR bursts, one outstanding.
// Latency: request handshake -> awvalid/arvalid two cycles later; read beats and B pass straight to rsp.
// Backpressure: req_ready only in IDLE; W and R/B streams pass ready through combinationally.
module sc_axi_master_bridge #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [ID_WIDTH-1:0]       req_id,
    input  logic [7:0]                req_len,

    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [ID_WIDTH-1:0]       rsp_id,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_last,
    output logic                      rsp_we,

    output logic [ID_WIDTH-1:0]       axi_awid,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,
    output logic                      axi_awlock,
    output logic [3:0]                axi_awcache,
    output logic [2:0]                axi_awprot,
    output logic [3:0]                axi_awqos,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,

    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,

    input  logic [ID_WIDTH-1:0]       axi_bid,
    input  logic [1:0]                axi_bresp,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,

    output logic [ID_WIDTH-1:0]       axi_arid,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic                      axi_arlock,
    output logic [3:0]                axi_arcache,
    output logic [2:0]                axi_arprot,
    output logic [3:0]                axi_arqos,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,

    input  logic [ID_WIDTH-1:0]       axi_rid,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rlast,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,

    output logic                      busy,
    output logic                      len_err,
    output logic [CNT_WIDTH-1:0]      wr_txn_cnt,
    output logic [CNT_WIDTH-1:0]      rd_txn_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CHK     = 3'd1;
    localparam logic [2:0] WR_ADDR = 3'd2;
    localparam logic [2:0] WR_DATA = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] RD_ADDR = 3'd5;
    localparam logic [2:0] RD_DATA = 3'd6;
    localparam logic [2:0] ERR_RSP = 3'd7;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [12:0]           end_off;
    logic                  chk_err;
    logic                  beat_is_last;
    logic                  w_hs;
    logic                  r_hs;
    logic                  b_hs;

    // Offset one past the burst within its 4 KB page; exactly 4096 is still legal.
    assign end_off      = {1'b0, addr_q[11:0]} + (({5'd0, len_q} + 13'd1) << 3);
    assign chk_err      = (addr_q[2:0] != 3'd0) || (end_off > 13'd4096);
    assign beat_is_last = (beat_cnt == len_q);

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);

    assign axi_awid     = id_q;
    assign axi_awaddr   = addr_q;
    assign axi_awlen    = len_q;
    assign axi_awsize   = 3'b011;
    assign axi_awburst  = 2'b01;
    assign axi_awlock   = 1'b0;
    assign axi_awcache  = 4'd0;
    assign axi_awprot   = 3'd0;
    assign axi_awqos    = 4'd0;
    assign axi_awvalid  = (state == WR_ADDR);

    assign axi_arid     = id_q;
    assign axi_araddr   = addr_q;
    assign axi_arlen    = len_q;
    assign axi_arsize   = 3'b011;
    assign axi_arburst  = 2'b01;
    assign axi_arlock   = 1'b0;
    assign axi_arcache  = 4'd0;
    assign axi_arprot   = 3'd0;
    assign axi_arqos    = 4'd0;
    assign axi_arvalid  = (state == RD_ADDR);

    assign axi_wdata    = wr_data;
    assign axi_wstrb    = wr_strb;
    assign axi_wlast    = beat_is_last;
    assign axi_wvalid   = (state == WR_DATA) && wr_valid;
    assign wr_ready     = (state == WR_DATA) && axi_wready;

    assign axi_bready   = (state == WR_RESP) && rsp_ready;
    assign axi_rready   = (state == RD_DATA) && rsp_ready;

    assign w_hs = axi_wvalid && axi_wready;
    assign r_hs = axi_rvalid && axi_rready;
    assign b_hs = axi_bvalid && axi_bready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = CHK;
            CHK:     state_nxt = chk_err ? ERR_RSP : (we_q ? WR_ADDR : RD_ADDR);
            WR_ADDR: if (axi_awready) state_nxt = WR_DATA;
            WR_DATA: if (w_hs && beat_is_last) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            RD_ADDR: if (axi_arready) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && axi_rlast) state_nxt = IDLE;
            ERR_RSP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_id    = '0;
        rsp_resp  = 2'b00;
        rsp_last  = 1'b0;
        rsp_we    = 1'b0;
        case (state)
            WR_RESP: begin
                rsp_valid = axi_bvalid;
                rsp_id    = axi_bid;
                rsp_resp  = axi_bresp;
                rsp_last  = 1'b1;
                rsp_we    = 1'b1;
            end
            RD_DATA: begin
                rsp_valid = axi_rvalid;
                rsp_data  = axi_rdata;
                rsp_id    = axi_rid;
                rsp_resp  = axi_rresp;
                rsp_last  = axi_rlast;
            end
            ERR_RSP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_resp  = 2'b10;
                rsp_last  = 1'b1;
                rsp_we    = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            id_q       <= '0;
            len_q      <= 8'd0;
            beat_cnt   <= 8'd0;
            len_err    <= 1'b0;
            wr_txn_cnt <= '0;
            rd_txn_cnt <= '0;
        end else begin
            state   <= state_nxt;
            len_err <= 1'b0;
            if ((state == IDLE) && req_valid) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                id_q     <= req_id;
                len_q    <= req_len;
                beat_cnt <= 8'd0;
            end
            if ((state == WR_DATA) && w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if ((state == WR_RESP) && b_hs) begin
                wr_txn_cnt <= wr_txn_cnt + CNT_WIDTH'(1);
            end
            // The slave's rlast ends the burst; a disagreeing beat count is only flagged.
            if ((state == RD_DATA) && r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                len_err  <= (axi_rlast != beat_is_last);
                if (axi_rlast) begin
                    rd_txn_cnt <= rd_txn_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_axi_master_bridge.sv
// Directed bench: table of request vectors against a scripted AXI slave, plus a mid-burst reset sequence.
module tb_sc_axi_master_bridge;
    localparam int DW = 64;
    localparam int AW = 40;
    localparam int IW = 12;
    localparam int CW = 16;

    logic clk;
    logic rst_n;
    logic req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] req_id;
    logic [7:0] req_len;
    logic wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] wr_strb;
    logic rsp_valid, rsp_ready, rsp_last, rsp_we;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_id;
    logic [1:0] rsp_resp;
    logic [IW-1:0] axi_awid, axi_arid, axi_bid, axi_rid;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic [7:0] axi_awlen, axi_arlen;
    logic [2:0] axi_awsize, axi_arsize, axi_awprot, axi_arprot;
    logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic axi_awlock, axi_arlock;
    logic [3:0] axi_awcache, axi_arcache, axi_awqos, axi_arqos;
    logic axi_awvalid, axi_awready, axi_arvalid, axi_arready;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic [DW/8-1:0] axi_wstrb;
    logic axi_wlast, axi_wvalid, axi_wready;
    logic axi_bvalid, axi_bready;
    logic axi_rlast, axi_rvalid, axi_rready;
    logic busy, len_err;
    logic [CW-1:0] wr_txn_cnt, rd_txn_cnt;

    sc_axi_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_id(req_id), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last), .rsp_we(rsp_we),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
        .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .busy(busy), .len_err(len_err), .wr_txn_cnt(wr_txn_cnt), .rd_txn_cnt(rd_txn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [7:0]    strb;
        logic [1:0]    bresp;
        bit            toggle;
        int            rlast_beat;
        bit            exp_err;
        int            exp_rsp_cnt;
        int            exp_last_idx;
        int            exp_len_err;
    } vec_t;

    vec_t vecs[8];
    int errors = 0;
    int checks = 0;
    int wr_exp = 0;
    int rd_exp = 0;

    int o_rsp_cnt, o_last_idx, o_aw_cnt, o_ar_cnt, o_wbeats, o_wlast_idx, o_len_err;
    int o_wdat_bad, o_rdat_bad, o_unstable, o_rready_bad, o_lat;
    logic o_wr_ready_seen, o_busy, o_timeout, o_we;
    logic [1:0] o_resp;
    logic [IW-1:0] o_id;
    logic [76:0] o_ax;

    function automatic logic [DW-1:0] wpat(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0100 + 32'(i)};
    endfunction

    function automatic logic [DW-1:0] rpat(input int i);
        return {32'hDEAD_0000 + 32'(i), 32'h1234_5600 + 32'(i)};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_id = '0; req_len = 8'd0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rsp_ready = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0;
        axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = 2'b00;
        axi_rvalid = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 1'b0;
    endtask

    // Acts as upstream and as AXI slave for one request; inputs change at posedge+1, sampling at negedge.
    task automatic run_txn(input vec_t v);
        int cyc, wbeat, rbeat, req_cyc, first_ax, idx;
        bit req_done, wdone, bdone, ar_done, done, aw_pend;
        logic [AW-1:0] aw_prev;
        logic [DW-1:0] exp_d;
        o_rsp_cnt = 0; o_last_idx = -1; o_aw_cnt = 0; o_ar_cnt = 0; o_wbeats = 0; o_wlast_idx = -1;
        o_len_err = 0; o_wdat_bad = 0; o_rdat_bad = 0; o_unstable = 0; o_rready_bad = 0;
        o_wr_ready_seen = 1'b0; o_resp = 2'b11; o_we = 1'bx; o_id = '0; o_ax = '0;
        cyc = 0; wbeat = 0; rbeat = 0; req_cyc = 0; first_ax = -1;
        req_done = 0; wdone = 0; bdone = 0; ar_done = 0; done = 0; aw_pend = 0; aw_prev = '0;
        while (!done && cyc < 400) begin
            req_valid = !req_done; req_we = v.we; req_addr = v.addr; req_id = v.id; req_len = v.len;
            axi_awready = (cyc % 2) == 1;
            wr_valid = 1'b1; wr_data = wpat(wbeat); wr_strb = v.strb;
            axi_wready = 1'b1;
            axi_bvalid = wdone && !bdone; axi_bid = v.id; axi_bresp = v.bresp;
            axi_arready = 1'b1;
            axi_rvalid = ar_done && (rbeat <= v.rlast_beat);
            axi_rdata = rpat(rbeat); axi_rid = v.id; axi_rresp = 2'b00;
            axi_rlast = (rbeat == v.rlast_beat);
            rsp_ready = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            #4;
            if (req_valid && req_ready) begin req_done = 1; req_cyc = cyc; end
            if (aw_pend && (!axi_awvalid || axi_awaddr !== aw_prev)) o_unstable++;
            aw_pend = axi_awvalid && !axi_awready;
            aw_prev = axi_awaddr;
            if ((axi_awvalid || axi_arvalid) && first_ax < 0) first_ax = cyc;
            if (axi_awvalid && axi_awready) begin
                o_aw_cnt++;
                o_ax = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache,
                        axi_awprot, axi_awqos, axi_awid};
            end
            if (axi_arvalid && axi_arready) begin
                o_ar_cnt++;
                ar_done = 1;
                o_ax = {axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache,
                        axi_arprot, axi_arqos, axi_arid};
            end
            if (wr_ready) o_wr_ready_seen = 1'b1;
            if (axi_wvalid && axi_wready) begin
                o_wbeats++;
                if (axi_wdata !== wpat(wbeat) || axi_wstrb !== v.strb) o_wdat_bad++;
                if (axi_wlast) begin wdone = 1; o_wlast_idx = wbeat; end
                wbeat++;
            end
            if (axi_rvalid && (axi_rready !== rsp_ready)) o_rready_bad++;
            if (axi_bvalid && axi_bready) bdone = 1;
            if (axi_rvalid && axi_rready) rbeat++;
            if (rsp_valid && rsp_ready) begin
                idx = o_rsp_cnt;
                o_rsp_cnt++;
                o_resp = rsp_resp; o_we = rsp_we; o_id = rsp_id;
                exp_d = (v.we || v.exp_err) ? '0 : rpat(idx);
                if (rsp_data !== exp_d) o_rdat_bad++;
                if (rsp_last && o_last_idx < 0) o_last_idx = idx;
                if (rsp_last) done = 1;
            end
            if (len_err) o_len_err++;
            tick();
            cyc++;
        end
        o_timeout = !done;
        idle();
        repeat (3) begin
            #4;
            if (len_err) o_len_err++;
            tick();
        end
        o_busy = busy;
        o_lat = first_ax - req_cyc;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        bit exp_aw, exp_ar;
        logic [1:0] exp_resp;
        exp_aw = v.we && !v.exp_err;
        exp_ar = !v.we && !v.exp_err;
        exp_resp = v.exp_err ? 2'b10 : (v.we ? v.bresp : 2'b00);
        run_txn(v);
        if (exp_aw) wr_exp++;
        if (exp_ar) rd_exp++;
        check($sformatf("v%0d_timeout", i), o_timeout, 0);
        check($sformatf("v%0d_rsp_cnt", i), o_rsp_cnt, v.exp_rsp_cnt);
        check($sformatf("v%0d_last_idx", i), o_last_idx, v.exp_last_idx);
        check($sformatf("v%0d_rsp_resp", i), o_resp, exp_resp);
        check($sformatf("v%0d_rsp_we", i), o_we, v.we);
        check($sformatf("v%0d_rsp_id", i), o_id, v.id);
        check($sformatf("v%0d_rsp_data", i), o_rdat_bad, 0);
        check($sformatf("v%0d_aw_cnt", i), o_aw_cnt, exp_aw);
        check($sformatf("v%0d_ar_cnt", i), o_ar_cnt, exp_ar);
        check($sformatf("v%0d_w_beats", i), o_wbeats, exp_aw ? int'(v.len) + 1 : 0);
        check($sformatf("v%0d_wr_ready_seen", i), o_wr_ready_seen, exp_aw);
        check($sformatf("v%0d_w_data", i), o_wdat_bad, 0);
        check($sformatf("v%0d_aw_stable", i), o_unstable, 0);
        check($sformatf("v%0d_rready_mirror", i), o_rready_bad, 0);
        check($sformatf("v%0d_len_err", i), o_len_err, v.exp_len_err);
        check($sformatf("v%0d_busy_after", i), o_busy, 0);
        check($sformatf("v%0d_wr_txn_cnt", i), wr_txn_cnt, wr_exp);
        check($sformatf("v%0d_rd_txn_cnt", i), rd_txn_cnt, rd_exp);
        if (exp_aw || exp_ar) begin
            check($sformatf("v%0d_addr_latency", i), o_lat, 2);
            check($sformatf("v%0d_ax_fields", i), o_ax,
                  {v.addr, v.len, 3'b011, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, v.id});
        end
        if (exp_aw) check($sformatf("v%0d_wlast_idx", i), o_wlast_idx, int'(v.len));
    endtask

    initial begin
        int n, hs;
        bit req_seen;
        //           we  addr                id      len    strb   bresp tgl rlb err cnt last lerr
        vecs[0] = '{1'b1, 40'h100,          12'h012, 8'd0,  8'hFF, 2'd0, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{1'b0, 40'h200,          12'h034, 8'd3,  8'hFF, 2'd0, 1, 3, 0, 4, 3, 0};
        vecs[2] = '{1'b0, 40'hFF8,          12'h056, 8'd1,  8'hFF, 2'd0, 0, 1, 1, 1, 0, 0};
        vecs[3] = '{1'b1, 40'h104,          12'h078, 8'd0,  8'hFF, 2'd0, 0, 0, 1, 1, 0, 0};
        vecs[4] = '{1'b0, 40'h300,          12'h09A, 8'd3,  8'hFF, 2'd0, 0, 1, 0, 2, 1, 1};
        vecs[5] = '{1'b1, 40'hF00,          12'hABC, 8'd31, 8'h0F, 2'd1, 1, 0, 0, 1, 0, 0};
        vecs[6] = '{1'b0, 40'h12_3456_7FF8, 12'hFFF, 8'd0,  8'hFF, 2'd0, 0, 0, 0, 1, 0, 0};
        vecs[7] = '{1'b1, 40'hF08,          12'h001, 8'd31, 8'hFF, 2'd0, 0, 0, 1, 1, 0, 0};

        idle();
        rst_n = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_awvalid", axi_awvalid, 0);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_wvalid", axi_wvalid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_len_err", len_err, 0);
        check("rst_wr_cnt", wr_txn_cnt, 0);
        check("rst_rd_cnt", rd_txn_cnt, 0);
        #20;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) check_vec(i, vecs[i]);

        // Reset while the second beat of an eight-beat write is on the W channel.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 40'h400; req_id = 12'h005; req_len = 8'd7;
        axi_awready = 1'b1; axi_wready = 1'b1; wr_valid = 1'b1; wr_strb = 8'hFF;
        n = 0; hs = 0; req_seen = 0;
        while (hs < 1 && n < 30) begin
            wr_data = wpat(hs);
            #4;
            if (req_valid && req_ready) req_seen = 1;
            if (axi_wvalid && axi_wready) hs++;
            tick();
            n++;
            if (req_seen) req_valid = 1'b0;
        end
        check("t6_first_beat", hs, 1);
        check("t6_wvalid_beat2", axi_wvalid, 1);
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_wvalid_rst", axi_wvalid, 0);
        check("t6_awvalid_rst", axi_awvalid, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_req_ready_rst", req_ready, 1);
        check("t6_wr_cnt_rst", wr_txn_cnt, 0);
        check("t6_rd_cnt_rst", rd_txn_cnt, 0);
        idle();
        #3;
        rst_n = 1'b1;
        wr_exp = 0;
        rd_exp = 0;
        tick();
        check_vec(8, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
